// File: rtl/bh_recv.sv
// UART 8N1 receiver for a Bluetooth serial link, feeding a 4-deep
// first-word-fall-through byte FIFO.
module bh_recv #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BPS_CNT / 2 - 1);
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Input synchronizer plus one history stage for edge detection.
  logic rxd_s1_reg;
  logic rxd_s2_reg;
  logic rxd_hist_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_s1_reg   <= 1'b1;
      rxd_s2_reg   <= 1'b1;
      rxd_hist_reg <= 1'b1;
    end else begin
      rxd_s1_reg   <= uart_rxd;
      rxd_s2_reg   <= rxd_s1_reg;
      rxd_hist_reg <= rxd_s2_reg;
    end
  end

  logic rxd_fall;
  assign rxd_fall = rxd_hist_reg & ~rxd_s2_reg;

  state_t           state_reg;
  logic [CNT_W-1:0] clk_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             rx_busy_reg;
  logic             frame_err_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      clk_cnt_reg   <= '0;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      rx_busy_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          clk_cnt_reg <= '0;
          if (rxd_fall) begin
            state_reg   <= START;
            rx_busy_reg <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt_reg == CNT_HALF) begin
            clk_cnt_reg <= '0;
            // A line that is high again mid start bit was only a glitch.
            if (rxd_s2_reg) begin
              state_reg   <= IDLE;
              rx_busy_reg <= 1'b0;
            end else begin
              state_reg   <= DATA;
              bit_cnt_reg <= 3'd0;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_reg == CNT_LAST) begin
            shift_reg[bit_cnt_reg] <= rxd_s2_reg;
            clk_cnt_reg            <= '0;
            bit_cnt_reg            <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7)
              state_reg <= STOP;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          // Leave mid stop bit so a directly following start edge is caught.
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg   <= '0;
            state_reg     <= IDLE;
            rx_busy_reg   <= 1'b0;
            frame_err_reg <= ~rxd_s2_reg;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          rx_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  logic wr_valid;
  assign wr_valid = (state_reg == STOP) && (clk_cnt_reg == CNT_LAST) && rxd_s2_reg;

  logic [7:0] mem_reg [FIFO_DEPTH];
  logic [1:0] wr_ptr_reg;
  logic [1:0] rd_ptr_reg;
  logic [2:0] count_reg;
  logic       overflow_reg;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count_reg == 3'd0);
  assign full    = (count_reg == 3'd4);
  assign do_pop  = rd_en & ~empty;
  // A pop in the same cycle frees the slot the write needs.
  assign do_push = wr_valid & (~full | do_pop);

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge sys_clk) begin
        if (sys_rst)
          mem_reg[gi] <= 8'h00;
        else if (do_push && (wr_ptr_reg == 2'(gi)))
          mem_reg[gi] <= shift_reg;
      end
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_reg   <= 2'd0;
      rd_ptr_reg   <= 2'd0;
      count_reg    <= 3'd0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= wr_valid & full & ~rd_en;
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout      = mem_reg[rd_ptr_reg];
  assign rx_busy   = rx_busy_reg;
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

endmodule
